maxnet_ctrl: RTL

Sequencing controller for a bank of N competing neuron blocks in the MaxNet layer. It drives the shared input/feedback select (`mux`) so the blocks first seed from their registered input and then iterate on their own registered ReLU outputs. Each cycle it watches the blocks' nonzero flags (`o`) and stops when exactly one survives, none survive, or the iteration limit is hit. It sits directly downstream of the neuron blocks, consuming their `o` outputs and reporting the winner index to the next layer.

---
 rtl/maxnet_ctrl_pkg.sv | 15 +
 rtl/maxnet_ctrl_if.sv | 33 +++
 rtl/maxnet_ctrl_onehot_detect.sv | 27 ++
 rtl/maxnet_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/maxnet_ctrl_pkg.sv
// maxnet_pkg: shared state encoding and default sizing for the MaxNet
// sequencing controller.
package maxnet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int ITER_W_DEF   = 8;
  localparam int MAX_ITER_DEF = 200;

endpackage

// File: rtl/maxnet_ctrl_if.sv
// maxnet_ctrl_if: handshake/status bundle between the neuron-block bank,
// the MaxNet controller and the downstream layer. The master side raises
// start and supplies the blocks' nonzero flags; the slave side is the
// controller.
interface maxnet_ctrl_if
  import maxnet_pkg::*;
#(
  parameter int N      = 4,
  parameter int IDX_W  = $clog2(N),
  parameter int ITER_W = ITER_W_DEF
) ();

  logic              start;
  logic [N-1:0]      o_vec;
  logic              mux;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  winner;
  logic              winner_valid;
  logic              timeout;
  logic [ITER_W-1:0] iter_count;

  modport master (
    output start, o_vec,
    input  mux, busy, done, winner, winner_valid, timeout, iter_count
  );

  modport slave (
    input  start, o_vec,
    output mux, busy, done, winner, winner_valid, timeout, iter_count
  );

endinterface

// File: rtl/maxnet_ctrl_onehot_detect.sv
// onehot_detect: purely combinational classification of the neuron
// nonzero flags into "none", "exactly one" and the lowest set index.
module onehot_detect #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     o_vec,
  output logic             is_zero,
  output logic             is_onehot,
  output logic [IDX_W-1:0] idx
);

  localparam logic [N-1:0] ONE = N'(1);

  assign is_zero   = (o_vec == '0);
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign is_onehot = !is_zero && ((o_vec & (o_vec - ONE)) == '0);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (o_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: sequences the MaxNet neuron bank (seed, then feedback
// iterations) and reports the surviving block.
// Optional feature: define MAXNET_TIMEOUT_EN to stop a run once
// iter_count reaches MAX_ITER; otherwise it iterates until convergence
// and timeout is tied low.
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int ITER_W   = ITER_W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic          clk,
  input  logic          rst,
  maxnet_ctrl_if.slave  bus
);

  // Reject configurations the counter or detector cannot represent.
  if (N < 2 || MAX_ITER >= (1 << ITER_W)) begin : g_bad_cfg
    $error("maxnet_ctrl: N must be >= 2 and MAX_ITER must fit in ITER_W");
  end

  state_t            state_q;
  logic              mux_q;
  logic              busy_q;
  logic              done_q;
  logic [IDX_W-1:0]  winner_q;
  logic              winner_valid_q;
  logic [ITER_W-1:0] iter_count_q;
  logic [ITER_W-1:0] iter_count_d;

  logic              is_zero;
  logic              is_onehot;
  logic [IDX_W-1:0]  hot_idx;

  onehot_detect #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_detect (
    .o_vec     (bus.o_vec),
    .is_zero   (is_zero),
    .is_onehot (is_onehot),
    .idx       (hot_idx)
  );

  // Saturating increment so a long run never wraps back to a small count.
  always_comb begin
    iter_count_d = iter_count_q;
    if (iter_count_q != '1) iter_count_d = iter_count_q + 1'b1;
  end

`ifdef MAXNET_TIMEOUT_EN
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  logic timeout_q;
`endif

  // Controller FSM with registered mux/busy/done and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      mux_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      iter_count_q   <= '0;
`ifdef MAXNET_TIMEOUT_EN
      timeout_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q        <= ST_SEED;
            busy_q         <= 1'b1;
            winner_valid_q <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
          end
        end
        ST_SEED: begin
          state_q      <= ST_ITER;
          mux_q        <= 1'b1;
          iter_count_q <= '0;
        end
        ST_ITER: begin
          if (is_onehot || is_zero) begin
            // A sole survivor or total collapse ends the run.
            winner_q       <= is_onehot ? hot_idx : '0;
            winner_valid_q <= is_onehot;
            state_q        <= ST_DONE;
            mux_q          <= 1'b0;
            done_q         <= 1'b1;
`ifdef MAXNET_TIMEOUT_EN
          end else if (iter_count_q == ITER_LIMIT) begin
            timeout_q      <= 1'b1;
            winner_valid_q <= 1'b0;
            state_q        <= ST_DONE;
            mux_q          <= 1'b0;
            done_q         <= 1'b1;
`endif
          end else begin
            iter_count_q <= iter_count_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          mux_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux          = mux_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.iter_count   = iter_count_q;
`ifdef MAXNET_TIMEOUT_EN
  assign bus.timeout      = timeout_q;
`else
  assign bus.timeout      = 1'b0;
`endif

endmodule
